// File: rtl/ff_video_pkg.sv
// Shared video types and sizing for the foodfight scan doubler.
package ff_video_pkg;

  localparam int DATA_W   = 8;
  localparam int H_MAX    = 512;
  localparam int ADDR_W   = $clog2(H_MAX);
  localparam int HS_WIDTH = 48;
  localparam int HS_CNT_W = $clog2(HS_WIDTH + 1);

  // Pixel counters carry one extra bit so a full H_MAX line can be represented.
  localparam logic [ADDR_W:0]   X_ZERO    = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   X_ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   X_LIMIT   = (ADDR_W+1)'(H_MAX);
  localparam logic [HS_CNT_W-1:0] HS_LOAD = HS_CNT_W'(HS_WIDTH);
  localparam logic [HS_CNT_W-1:0] HS_ZERO = {HS_CNT_W{1'b0}};

  // One stored pixel: blank flag travels with the colour.
  typedef struct packed {
    logic              blank;
    logic [DATA_W-1:0] rgb;
  } pixel_t;

  // Replay state of the read side.
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PASS1 = 2'd1,
    RD_PASS2 = 2'd2
  } rd_state_t;

  // True when rd_x addresses the last pixel of a line of length len.
  function automatic logic is_last_px(input logic [ADDR_W-1:0] rd_x,
                                      input logic [ADDR_W:0]   len);
    return ({1'b0, rd_x} == (len - X_ONE));
  endfunction

endpackage

// File: rtl/ff_linebuf.sv
// Ping-pong line store: two banks of H_MAX pixels, address = {bank, x}.
// One write port and one synchronous read port on the same clock.
module ff_linebuf
  import ff_video_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  pixel_t          wdata,
  input  logic [ADDR_W:0] raddr,
  output pixel_t          rdata
);

  pixel_t mem_r [0:2*H_MAX-1];

  // Write port: store the incoming pixel when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: one-cycle registered read.
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/ff_scandoubler.sv
// 15 kHz -> 31 kHz scan doubler: each input line is captured into one bank
// of a ping-pong buffer and replayed twice at the full clk12m rate while the
// next line fills the other bank.
module ff_scandoubler
  import ff_video_pkg::*;
(
  input  logic              clk12m,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_blank,
  input  logic [DATA_W-1:0] in_rgb,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_blank,
  output logic [DATA_W-1:0] out_rgb,
  output logic [ADDR_W:0]   line_len,
  output logic              ovf
);

  // Write side state
  logic            hs_prev_r;
  logic            edge_s;
  logic [ADDR_W:0] wr_x_r;
  logic            wr_bank_r;
  logic            seen_r;
  logic            valid_r;
  logic            ovf_r;
  logic [ADDR_W:0] line_len_r;
  logic            we_s;
  logic [ADDR_W:0] waddr_s;
  pixel_t          wdata_s;

  // Read side state
  rd_state_t             state_r, state_nx;
  logic [ADDR_W-1:0]     rd_x_r, rd_x_nx;
  logic                  rd_bank_r, rd_bank_nx;
  logic [HS_CNT_W-1:0]   hs_cnt_r, hs_cnt_nx;
  logic                  vs_r, vs_nx;
  logic                  start_ok_s;
  logic                  last_s;
  logic [ADDR_W:0]       raddr_s;
  pixel_t                rdata_s;

  // Output alignment pipe (matches the RAM read latency)
  logic act_d1_r;
  logic hs_d1_r;
  logic vs_d1_r;

  // Edge detect and write-port steering for the current pix_ce.
  always_comb begin
    edge_s        = pix_ce & in_hsync & ~hs_prev_r;
    we_s          = 1'b0;
    waddr_s       = {wr_bank_r, wr_x_r[ADDR_W-1:0]};
    wdata_s.blank = in_blank;
    wdata_s.rgb   = in_rgb;
    if (edge_s) begin
      // First pixel of the new line lands at x=0 of the other bank.
      we_s    = 1'b1;
      waddr_s = {~wr_bank_r, {ADDR_W{1'b0}}};
    end else if (pix_ce && (wr_x_r < X_LIMIT)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Write counter, bank toggle, line length capture and overflow flag.
  always_ff @(posedge clk12m or posedge reset) begin
    if (reset) begin
      hs_prev_r  <= 1'b0;
      wr_x_r     <= X_ZERO;
      wr_bank_r  <= 1'b0;
      seen_r     <= 1'b0;
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
      line_len_r <= X_ZERO;
    end else if (pix_ce) begin
      hs_prev_r <= in_hsync;
      if (edge_s) begin
        line_len_r <= wr_x_r;
        wr_bank_r  <= ~wr_bank_r;
        wr_x_r     <= X_ONE;
        seen_r     <= 1'b1;
        // The line ending at the first edge started mid-line; only the second edge yields a whole line.
        valid_r    <= valid_r | seen_r;
      end else if (wr_x_r < X_LIMIT) begin
        wr_x_r <= wr_x_r + X_ONE;
      end else begin
        ovf_r <= 1'b1;
      end
    end
  end

  ff_linebuf u_linebuf (
    .clk   (clk12m),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  assign raddr_s    = {rd_bank_r, rd_x_r};
  // A pass may start only when the line just finished is whole and non-empty.
  assign start_ok_s = edge_s & (valid_r | seen_r) & (wr_x_r != X_ZERO);
  assign last_s     = is_last_px(rd_x_r, line_len_r);

  // Read FSM next state, hsync pulse counter and vsync capture.
  always_comb begin
    state_nx   = state_r;
    rd_x_nx    = rd_x_r;
    rd_bank_nx = rd_bank_r;
    vs_nx      = vs_r;
    if (hs_cnt_r != HS_ZERO) begin
      hs_cnt_nx = hs_cnt_r - {{(HS_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      hs_cnt_nx = hs_cnt_r;
    end

    if (edge_s) begin
      // Any edge abandons whatever pass is running.
      if (start_ok_s) begin
        state_nx   = RD_PASS1;
        rd_x_nx    = {ADDR_W{1'b0}};
        rd_bank_nx = wr_bank_r;
        hs_cnt_nx  = HS_LOAD;
        vs_nx      = in_vsync;
      end else begin
        state_nx = RD_IDLE;
        rd_x_nx  = {ADDR_W{1'b0}};
      end
    end else begin
      case (state_r)
        RD_IDLE: begin
          state_nx = RD_IDLE;
        end
        RD_PASS1: begin
          if (last_s) begin
            state_nx  = RD_PASS2;
            rd_x_nx   = {ADDR_W{1'b0}};
            hs_cnt_nx = HS_LOAD;
            vs_nx     = in_vsync;
          end else begin
            rd_x_nx = rd_x_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        RD_PASS2: begin
          if (last_s) begin
            state_nx = RD_IDLE;
            rd_x_nx  = {ADDR_W{1'b0}};
          end else begin
            rd_x_nx = rd_x_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nx = RD_IDLE;
          rd_x_nx  = {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Read FSM and pulse counter registers.
  always_ff @(posedge clk12m or posedge reset) begin
    if (reset) begin
      state_r   <= RD_IDLE;
      rd_x_r    <= {ADDR_W{1'b0}};
      rd_bank_r <= 1'b0;
      hs_cnt_r  <= HS_ZERO;
      vs_r      <= 1'b0;
    end else begin
      state_r   <= state_nx;
      rd_x_r    <= rd_x_nx;
      rd_bank_r <= rd_bank_nx;
      hs_cnt_r  <= hs_cnt_nx;
      vs_r      <= vs_nx;
    end
  end

  // Delay control one cycle to line up with the RAM read data.
  always_ff @(posedge clk12m or posedge reset) begin
    if (reset) begin
      act_d1_r <= 1'b0;
      hs_d1_r  <= 1'b0;
      vs_d1_r  <= 1'b0;
    end else begin
      act_d1_r <= (state_r != RD_IDLE);
      hs_d1_r  <= (hs_cnt_r != HS_ZERO);
      vs_d1_r  <= vs_r;
    end
  end

  // Registered video outputs; idle shows blank black.
  always_ff @(posedge clk12m or posedge reset) begin
    if (reset) begin
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_blank <= 1'b1;
      out_rgb   <= {DATA_W{1'b0}};
    end else begin
      out_hsync <= hs_d1_r;
      out_vsync <= vs_d1_r;
      if (act_d1_r) begin
        out_blank <= rdata_s.blank;
        out_rgb   <= rdata_s.rgb;
      end else begin
        out_blank <= 1'b1;
        out_rgb   <= {DATA_W{1'b0}};
      end
    end
  end

  assign line_len = line_len_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_ff_scandoubler.sv
// Directed bench for ff_scandoubler: drives 15 kHz lines and checks the doubled replay.
module tb_ff_scandoubler;

  logic       clk12m;
  logic       reset;
  logic       pix_ce;
  logic       in_hsync;
  logic       in_vsync;
  logic       in_blank;
  logic [7:0] in_rgb;
  logic       out_hsync;
  logic       out_vsync;
  logic       out_blank;
  logic [7:0] out_rgb;
  logic [9:0] line_len;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  logic vs  = 1'b0;

  ff_scandoubler dut (
    .clk12m    (clk12m),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .in_blank  (in_blank),
    .in_rgb    (in_rgb),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_blank (out_blank),
    .out_rgb   (out_rgb),
    .line_len  (line_len),
    .ovf       (ovf)
  );

  initial clk12m = 1'b0;
  always #5 clk12m = ~clk12m;

  // Drive one input line (pixel p has rgb = p+off, blank when p%128==127) for ncyc
  // clocks starting at its hsync edge, checking the replay of the previous line
  // (length plen, colour offset poff). plen=0 expects idle, plen<0 skips checks.
  // tail_j>=0 checks the first two cycles against a truncated earlier pass.
  task automatic run_line(input int npx, input int ncyc, input int off,
                          input int plen, input int poff,
                          input int tail_j, input int tail_off);
    for (int c = 0; c < ncyc; c++) begin
      int p;
      int k;
      int j;
      logic [7:0] erg;
      logic ebl;
      logic ehs;
      p = c / 2;
      in_vsync = vs;
      if ((c % 2 == 0) && (p < npx)) begin
        pix_ce   = 1'b1;
        in_hsync = (p < 8);
        in_blank = (p % 128 == 127);
        in_rgb   = 8'(p + off);
      end else begin
        pix_ce = 1'b0;
      end
      @(negedge clk12m);
      if (c < 2 && tail_j >= 0) begin
        erg = 8'(tail_j + c + tail_off);
        total++;
        if (out_rgb !== erg) begin
          bad++;
          $display("FAIL tail_rgb c=%0d got %h exp %h", c, out_rgb, erg);
        end
        total++;
        if (out_hsync !== 1'b1) begin
          bad++;
          $display("FAIL tail_hsync c=%0d got %b exp 1", c, out_hsync);
        end
      end
      if (c >= 2 && plen >= 0) begin
        k = c - 2;
        if (plen > 0 && k < 2 * plen) begin
          j   = (k < plen) ? k : k - plen;
          erg = 8'(j + poff);
          ebl = (j % 128 == 127);
        end else begin
          erg = 8'h00;
          ebl = 1'b1;
        end
        ehs = (plen > 0) && ((k < 48) || (k >= plen && k < plen + 48));
        total++;
        if (out_rgb !== erg) begin
          bad++;
          $display("FAIL rgb off=%h c=%0d got %h exp %h", off, c, out_rgb, erg);
        end
        total++;
        if (out_blank !== ebl) begin
          bad++;
          $display("FAIL blank off=%h c=%0d got %b exp %b", off, c, out_blank, ebl);
        end
        total++;
        if (out_hsync !== ehs) begin
          bad++;
          $display("FAIL hsync off=%h c=%0d got %b exp %b", off, c, out_hsync, ehs);
        end
        if (plen > 0 && (c == 2 || c == plen + 2)) begin
          total++;
          if (out_vsync !== vs) begin
            bad++;
            $display("FAIL vsync off=%h c=%0d got %b exp %b", off, c, out_vsync, vs);
          end
        end
      end
    end
    pix_ce   = 1'b0;
    in_hsync = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    pix_ce = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_blank = 1'b0; in_rgb = 8'h00;
    #2 reset = 1'b1;
    #1;
    total++; if (out_blank !== 1'b1) begin bad++; $display("FAIL rst_blank got %b exp 1", out_blank); end
    total++; if (out_hsync !== 1'b0) begin bad++; $display("FAIL rst_hsync got %b exp 0", out_hsync); end
    total++; if (out_vsync !== 1'b0) begin bad++; $display("FAIL rst_vsync got %b exp 0", out_vsync); end
    total++; if (out_rgb !== 8'h00) begin bad++; $display("FAIL rst_rgb got %h exp 00", out_rgb); end
    total++; if (line_len !== 10'd0) begin bad++; $display("FAIL rst_len got %0d exp 0", line_len); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    repeat (3) @(negedge clk12m);
    reset = 1'b0;
  endtask

  task automatic test_lines;
    vs = 1'b0;
    run_line(384, 768, 8'h00, 0, 0, -1, 0);
    run_line(384, 768, 8'h10, 384, 8'h00, -1, 0);
    vs = 1'b1;
    run_line(384, 768, 8'h20, 384, 8'h10, -1, 0);
    vs = 1'b0;
    total++; if (line_len !== 10'd384) begin bad++; $display("FAIL lines_len got %0d exp 384", line_len); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL lines_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_overflow;
    run_line(600, 1200, 8'h30, 384, 8'h20, -1, 0);
    run_line(384, 768, 8'h40, -1, 0, -1, 0);
    total++; if (line_len !== 10'd512) begin bad++; $display("FAIL ovf_len got %0d exp 512", line_len); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got %b exp 1", ovf); end
    run_line(384, 768, 8'h50, -1, 0, -1, 0);
    total++; if (line_len !== 10'd384) begin bad++; $display("FAIL ovf_len2 got %0d exp 384", line_len); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_truncate;
    run_line(200, 400, 8'h60, 384, 8'h50, -1, 0);
    run_line(384, 768, 8'h70, 200, 8'h60, 14, 8'h50);
    total++; if (line_len !== 10'd200) begin bad++; $display("FAIL trunc_len got %0d exp 200", line_len); end
  endtask

  task automatic test_reset_mid;
    run_line(50, 100, 8'h80, 384, 8'h70, -1, 0);
    total++; if (out_blank !== 1'b0) begin bad++; $display("FAIL mid_active got %b exp 0", out_blank); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_blank !== 1'b1) begin bad++; $display("FAIL mid_blank got %b exp 1", out_blank); end
    total++; if (out_hsync !== 1'b0) begin bad++; $display("FAIL mid_hsync got %b exp 0", out_hsync); end
    total++; if (out_rgb !== 8'h00) begin bad++; $display("FAIL mid_rgb got %h exp 00", out_rgb); end
    total++; if (line_len !== 10'd0) begin bad++; $display("FAIL mid_len got %0d exp 0", line_len); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf got %b exp 0", ovf); end
    repeat (3) @(negedge clk12m);
    reset = 1'b0;
    run_line(384, 768, 8'h90, 0, 0, -1, 0);
    run_line(384, 768, 8'hA0, 384, 8'h90, -1, 0);
    total++; if (line_len !== 10'd384) begin bad++; $display("FAIL post_len got %0d exp 384", line_len); end
  endtask

  task automatic test_ce_stop;
    run_line(1, 1000, 8'hB0, 384, 8'hA0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_lines();
    test_overflow();
    test_truncate();
    test_reset_mid();
    test_ce_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
